// File: rtl/ps2_pkg.sv
// Shared types and frame constants for the PS/2 device->host receiver.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam int unsigned FRAME_DATA_BITS = 8;
  localparam logic        START_BIT       = 1'b0;
  localparam logic        STOP_BIT        = 1'b1;

  // Odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic parity_bad(input logic [FRAME_DATA_BITS-1:0] data,
                                      input logic                       par);
    return ~(^{data, par});
  endfunction

endpackage

// File: rtl/ps2_rx_fifo.sv
// Synchronous FIFO for received bytes; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module ps2_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             push_ok, pop_ok;

  always_comb begin
    empty    = (wr_q == rd_q);
    full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    pop_data = mem_q[rd_q[AW-1:0]];
    mem_d    = mem_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    if (push_ok) begin
      mem_d[wr_q[AW-1:0]] = push_data;
      wr_d                = wr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device->host receiver: synchronize, deglitch ps2_clk, deframe, check, queue.
// Optional mid-frame timeout abort is built when PS2_RX_TIMEOUT_EN is defined.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overflow
);

  localparam int unsigned FCW = $clog2(FILTER_LEN) + 1;
  localparam int unsigned BCW = $clog2(FRAME_DATA_BITS);

  logic clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d;
  logic dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  logic filt_q, filt_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic fall_ev;

  state_e state_q, state_d;
  logic [BCW-1:0] bitcnt_q, bitcnt_d;
  logic [FRAME_DATA_BITS-1:0] shift_q, shift_d;
  logic perr_q, perr_d;
  logic parity_err_q, parity_err_d;
  logic frame_err_q, frame_err_d;
  logic overflow_q, overflow_d;
  logic push, pop, timeout;
  logic fifo_full, fifo_empty;

  // Synchronizers and ps2_clk deglitch filter.
  always_comb begin
    clk_s1_d = ps2_clk;
    clk_s2_d = clk_s1_q;
    dat_s1_d = ps2_dat;
    dat_s2_d = dat_s1_q;
    filt_d   = filt_q;
    fcnt_d   = '0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
        filt_d = clk_s2_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
    fall_ev = filt_q && !filt_d;
  end

`ifdef PS2_RX_TIMEOUT_EN
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] to_cnt_q, to_cnt_d;

  always_comb begin
    to_cnt_d = '0;
    timeout  = 1'b0;
    if (state_q != IDLE && !fall_ev) begin
      if (to_cnt_q == TCW'(TIMEOUT_CYCLES - 1)) begin
        timeout = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  always_comb begin
    timeout            = 1'b0;
    unused_timeout_cfg = ^TIMEOUT_CYCLES;
  end
`endif

  always_comb begin
    state_d      = state_q;
    bitcnt_d     = bitcnt_q;
    shift_d      = shift_q;
    perr_d       = perr_q;
    push         = 1'b0;
    parity_err_d = 1'b0;
    frame_err_d  = 1'b0;
    if (fall_ev) begin
      case (state_q)
        IDLE: begin
          if (dat_s2_q == START_BIT) begin
            state_d  = DATA;
            bitcnt_d = '0;
          end
        end
        DATA: begin
          shift_d  = {dat_s2_q, shift_q[FRAME_DATA_BITS-1:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          if (bitcnt_q == BCW'(FRAME_DATA_BITS - 1)) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          perr_d  = parity_bad(shift_q, dat_s2_q);
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (dat_s2_q != STOP_BIT) begin
            frame_err_d = 1'b1;
          end else if (perr_q) begin
            parity_err_d = 1'b1;
          end else begin
            push = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout) begin
      state_d     = IDLE;
      frame_err_d = 1'b1;
    end
    pop        = !fifo_empty && out_ready;
    overflow_d = push && fifo_full && !pop;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      clk_s1_q     <= 1'b1;
      clk_s2_q     <= 1'b1;
      dat_s1_q     <= 1'b1;
      dat_s2_q     <= 1'b1;
      filt_q       <= 1'b1;
      fcnt_q       <= '0;
      state_q      <= IDLE;
      bitcnt_q     <= '0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      clk_s1_q     <= clk_s1_d;
      clk_s2_q     <= clk_s2_d;
      dat_s1_q     <= dat_s1_d;
      dat_s2_q     <= dat_s2_d;
      filt_q       <= filt_d;
      fcnt_q       <= fcnt_d;
      state_q      <= state_d;
      bitcnt_q     <= bitcnt_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
    end
  end

  ps2_rx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(FRAME_DATA_BITS)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_data(shift_q),
    .pop      (pop),
    .pop_data (out_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign out_valid  = !fifo_empty;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Randomized bench for ps2_rx against a frame-level reference model.
module tb_ps2_rx;

  localparam int unsigned FILTER_LEN     = 4;
  localparam int unsigned FIFO_DEPTH     = 4;
  localparam int unsigned TIMEOUT_CYCLES = 2000;
  localparam int          HALF           = 10;
  localparam int          GAP            = 40;
  localparam int          NONE           = 99;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid, parity_err, frame_err, overflow;

  always #5 clk = ~clk;

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .FIFO_DEPTH    (FIFO_DEPTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .parity_err(parity_err),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  int unsigned n_checks = 0, n_errors = 0;
  logic [7:0]  exp_q[$], rx_q[$];
  int unsigned exp_perr = 0, exp_ferr = 0, exp_ovf = 0;
  int unsigned act_perr = 0, act_ferr = 0, act_ovf = 0;
  int unsigned multi_pulse = 0, unstable = 0, model_occ = 0;
  logic        prev_hold = 1'b0;
  logic [7:0]  prev_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_hold <= 1'b0;
    end else begin
      if (prev_hold && out_data !== prev_data) unstable <= unstable + 1;
      prev_hold <= out_valid && !out_ready;
      prev_data <= out_data;
      if (out_valid && out_ready) rx_q.push_back(out_data);
      if (parity_err) act_perr <= act_perr + 1;
      if (frame_err) act_ferr <= act_ferr + 1;
      if (overflow) act_ovf <= act_ovf + 1;
      if (32'(parity_err) + 32'(frame_err) + 32'(overflow) > 1) multi_pulse <= multi_pulse + 1;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference: what one complete frame should produce, by the frame rules.
  task automatic model_frame(input logic [7:0] d, input logic par_flip, input logic stop_v);
    if (!stop_v) exp_ferr++;
    else if (par_flip) exp_perr++;
    else if (model_occ >= FIFO_DEPTH) exp_ovf++;
    else begin
      exp_q.push_back(d);
      if (!out_ready) model_occ++;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_v,
                            input int abort_at, input int stall_at, input int stall_len);
    logic [10:0] bits;
    bits = {stop_v, (~^d) ^ par_flip, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      if (i == abort_at) begin
        ps2_dat = 1'b1;
        wait_clks(GAP);
        return;
      end
      if (i == stall_at) wait_clks(stall_len);
      ps2_dat = bits[i];
      wait_clks(HALF);
      ps2_clk = 1'b0;
      wait_clks(HALF);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    wait_clks(GAP);
  endtask

  task automatic frame(input logic [7:0] d, input logic par_flip, input logic stop_v);
    model_frame(d, par_flip, stop_v);
    send_frame(d, par_flip, stop_v, NONE, NONE, 0);
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_count"}, rx_q.size(), exp_q.size());
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      check({tag, "_byte"}, rx_q.pop_front(), exp_q.pop_front());
    end
    exp_q.delete();
    rx_q.delete();
    check({tag, "_perr"}, act_perr, exp_perr);
    check({tag, "_ferr"}, act_ferr, exp_ferr);
    check({tag, "_ovf"}, act_ovf, exp_ovf);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_data"}, out_data, 8'h00);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_pulses"}, {parity_err, frame_err, overflow}, 3'b000);
  endtask

  initial begin
    wait_clks(5);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    wait_clks(20);

    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) frame(8'(i), 1'b0, 1'b1);
    compare_all("seq");

    frame(8'hA5, 1'b1, 1'b1);
    @(negedge clk);
    check("perr_no_valid", out_valid, 1'b0);
    frame(8'h5A, 1'b0, 1'b1);
    compare_all("parity");

    frame(8'h3C, 1'b0, 1'b0);
    frame(8'h3D, 1'b0, 1'b1);
    compare_all("stop");

    for (int i = 0; i < 10; i++) begin
      int unsigned kind;
      kind = $urandom_range(0, 3);
      frame(8'($urandom), kind == 2, kind != 3);
    end
    compare_all("rand");

    out_ready = 1'b0;
    model_occ = 0;
    for (int i = 0; i < 5; i++) frame(8'(8'h10 + i), 1'b0, 1'b1);
    @(negedge clk);
    check("full_valid", out_valid, 1'b1);
    check("full_head", out_data, 8'h10);
    out_ready = 1'b1;
    wait_clks(10);
    model_occ = 0;
    compare_all("ovf");

    // Short low glitch with dat low would look like a start bit if it got through.
    ps2_dat = 1'b0;
    ps2_clk = 1'b0;
    wait_clks(1);
    ps2_clk = 1'b1;
    wait_clks(5);
    ps2_dat = 1'b1;
    wait_clks(20);
    frame(8'h6B, 1'b0, 1'b1);
    compare_all("glitch");

    out_ready = 1'b0;
    frame(8'h42, 1'b0, 1'b1);
    send_frame(8'h99, 1'b0, 1'b1, 5, NONE, 0);
    reset_n = 1'b0;
    wait_clks(3);
    check_reset_outputs("midreset");
    exp_q.delete();
    rx_q.delete();
    model_occ = 0;
    reset_n = 1'b1;
    out_ready = 1'b1;
    wait_clks(10);
    frame(8'h77, 1'b0, 1'b1);
    compare_all("after_reset");

    model_frame(8'hC3, 1'b0, 1'b1);
    send_frame(8'hC3, 1'b0, 1'b1, NONE, 5, 300);
    compare_all("stall");

`ifdef PS2_RX_TIMEOUT_EN
    send_frame(8'h81, 1'b0, 1'b1, 5, NONE, 0);
    wait_clks(int'(TIMEOUT_CYCLES) + 2);
    exp_ferr++;
    frame(8'h55, 1'b0, 1'b1);
    compare_all("timeout");
`endif

    check("multi_pulse", multi_pulse, 0);
    check("data_stable", unstable, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
